// File: rtl/uart_pkg.sv
// Shared types and constants for the routed UART transmitter.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, START, DATA, PARITY, STOP} tx_state_t;
  localparam int   CLKS_PER_BIT_DEFAULT = 434;
  localparam logic UART_IDLE_LVL        = 1'b1;
endpackage

// File: rtl/uart_tx_route_if.sv
// Upstream byte handshake into the routed UART transmitter.
interface uart_tx_route_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] tx_data;
  logic [1:0]           tx_chan;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, tx_chan, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_chan, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter: tick pulses for one cycle at count CLKS_PER_BIT-1, then wraps.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else if (en)           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_route.sv
// 8N1 UART transmitter that also drives the selector's channel lines {s1,s0},
// switching them only between frames. Optional parity bit: UART_TX_PARITY_EN.
module uart_tx_route
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = 8
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_route_if.slave   up,
  output logic             tx,
  output logic             s0,
  output logic             s1,
  output logic             busy
);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  tx_state_t            state, next;
  logic [1:0]           rst_sync;
  logic                 rst_n;
  logic                 tick;
  logic                 last_bit;
  logic                 take;
  logic [DATA_BITS-1:0] data_q;
  logic [BW-1:0]        bit_idx;
  logic [1:0]           sel;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .reset (rst_n),
    .clr   (state == IDLE),
    .en    (state != IDLE),
    .tick  (tick)
  );

  assign last_bit = (bit_idx == BW'(DATA_BITS - 1));
  assign take     = (state == IDLE) && up.tx_valid;
  assign {s1, s0} = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next        = state;
    tx          = UART_IDLE_LVL;
    up.tx_ready = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        up.tx_ready = 1'b1;
        busy        = 1'b0;
        if (up.tx_valid) next = (up.tx_chan != sel) ? SETUP : START;
      end
      // Line held idle on the freshly selected port so the selector settles.
      SETUP:  if (tick) next = START;
      START: begin
        tx = 1'b0;
        if (tick) next = DATA;
      end
      DATA: begin
        tx = data_q[bit_idx];
        if (tick && last_bit) next = AFTER_DATA;
      end
      PARITY: begin
        tx = ^data_q;
        if (tick) next = STOP;
      end
      STOP:    if (tick) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel     <= '0;
      bit_idx <= '0;
    end else begin
      if (take) begin
        data_q <= up.tx_data;
        if (up.tx_chan != sel) sel <= up.tx_chan;
      end
      if (state == DATA && tick) bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
    end
  end
endmodule
